// File: rtl/tile_query_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : tile_query_sched_if
//  Description : Tile-ROM read bus shared between the query scheduler and the
//                level-map ROM. 1 bit per tile (0 = path, 1 = wall).
//                Signals:
//                  rom_rd    - read strobe, one cycle per query
//                  rom_addr  - tile index = tile_y*TILES_X + tile_x
//                  rom_data  - is_wall, valid ROM_LAT cycles after rom_rd
//                Modports: master (scheduler side), slave (ROM side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tile_query_sched_if;
    logic       rom_rd;
    logic [9:0] rom_addr;
    logic       rom_data;

    modport master (output rom_rd, output rom_addr, input rom_data);
    modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface
`default_nettype wire

// File: rtl/tile_query_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tile_query_sched
//  Description : Per-frame scheduler time-sharing one tile ROM among N_ACT
//                actors. On frame_tick the actor positions/directions are
//                snapshotted, the tile just ahead of each hitbox is queried in
//                turn, and all blocked flags are published at once with done.
//  Ports       : pclk, rst_n (async, active-low)
//                frame_tick        - start-of-frame pulse
//                act_valid/x/y/dir - per-actor state, actor k at slice k
//                rom               - tile ROM bus (master modport)
//                blocked           - per-actor wall-ahead flags
//                busy/done/overrun - sequence status pulses
//  Option      : TQS_OUT_OF_MAZE_EN - a valid actor outside the maze is
//                reported blocked without a ROM access. When undefined the
//                position is clamped into the maze and queried normally.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_query_sched #(
    parameter int N_ACT   = 5,
    parameter int TILES_X = 28,
    parameter int TILES_Y = 36,
    parameter int ROM_LAT = 1,
    parameter int HIT_R   = 7
) (
    input  wire                   pclk,
    input  wire                   rst_n,
    input  wire                   frame_tick,
    input  wire  [N_ACT-1:0]      act_valid,
    input  wire  [9*N_ACT-1:0]    act_x,
    input  wire  [9*N_ACT-1:0]    act_y,
    input  wire  [2*N_ACT-1:0]    act_dir,
    tile_query_sched_if.master    rom,
    output logic [N_ACT-1:0]      blocked,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int                 C_IDX_W    = (N_ACT > 1) ? $clog2(N_ACT) : 1;
    localparam int                 C_CNT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [9:0]         C_MAX_X    = 10'(TILES_X * 8 - 1);
    localparam logic [9:0]         C_MAX_Y    = 10'(TILES_Y * 8 - 1);
    localparam logic [9:0]         C_HIT_R    = 10'(HIT_R);
    localparam logic [9:0]         C_TILES_X  = 10'(TILES_X);
    localparam logic [C_IDX_W-1:0] C_LAST     = C_IDX_W'(N_ACT - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_IDX_W-1:0]   idx_q, idx_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_ACT-1:0]     valid_q, valid_d;
    logic [8:0]           x_q [N_ACT];
    logic [8:0]           x_d [N_ACT];
    logic [8:0]           y_q [N_ACT];
    logic [8:0]           y_d [N_ACT];
    logic [1:0]           dir_q [N_ACT];
    logic [1:0]           dir_d [N_ACT];
    logic [N_ACT-1:0]     shadow_q, shadow_d;
    logic [N_ACT-1:0]     blocked_q, blocked_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    logic                 w_oom;
    logic                 w_adv;
    logic                 w_rom_rd;
    logic [9:0]           w_rom_addr;
    logic [9:0]           w_addr;

    // Front-sample tile index. Positions are clamped into the maze first and
    // the offset sample is saturated at the maze edges so it never wraps.
    // The row multiply is a shift/add over the set bits of TILES_X.
    function automatic logic [9:0] sample_addr(input logic [8:0] x,
                                               input logic [8:0] y,
                                               input logic [1:0] dir);
        logic [9:0] cx, cy, sx, sy, tx, ty, acc;
        cx = ({1'b0, x} > C_MAX_X) ? C_MAX_X : {1'b0, x};
        cy = ({1'b0, y} > C_MAX_Y) ? C_MAX_Y : {1'b0, y};
        sx = cx;
        sy = cy;
        case (dir)
            2'd0:    sx = (cx + C_HIT_R > C_MAX_X) ? C_MAX_X : cx + C_HIT_R;
            2'd1:    sx = (cx > C_HIT_R) ? cx - C_HIT_R : 10'd0;
            2'd2:    sy = (cy > C_HIT_R) ? cy - C_HIT_R : 10'd0;
            default: sy = (cy + C_HIT_R > C_MAX_Y) ? C_MAX_Y : cy + C_HIT_R;
        endcase
        tx  = sx >> 3;
        ty  = sy >> 3;
        acc = tx;
        for (int b = 0; b < 10; b++) begin
            if (C_TILES_X[b]) begin
                acc = acc + (ty << b);
            end
        end
        return acc;
    endfunction

    assign w_addr = sample_addr(x_q[idx_q], y_q[idx_q], dir_q[idx_q]);

`ifdef TQS_OUT_OF_MAZE_EN
    assign w_oom = ({1'b0, x_q[idx_q]} > C_MAX_X) || ({1'b0, y_q[idx_q]} > C_MAX_Y);
`else
    assign w_oom = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        shadow_d   = shadow_q;
        blocked_d  = blocked_q;
        done_d     = 1'b0;
        overrun_d  = frame_tick && (state_q != S_IDLE);
        w_adv      = 1'b0;
        w_rom_rd   = 1'b0;
        w_rom_addr = 10'd0;

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    valid_d = act_valid;
                    for (int k = 0; k < N_ACT; k++) begin
                        x_d[k]   = act_x[9*k +: 9];
                        y_d[k]   = act_y[9*k +: 9];
                        dir_d[k] = act_dir[2*k +: 2];
                    end
                    idx_d    = '0;
                    shadow_d = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (valid_q[idx_q] && !w_oom) begin
                    w_rom_rd   = 1'b1;
                    w_rom_addr = w_addr;
                    cnt_d      = C_CNT_INIT;
                    state_d    = S_WAIT;
                end else begin
                    // Invalid actors read as clear; out-of-maze ones as blocked.
                    shadow_d[idx_q] = valid_q[idx_q];
                    w_adv           = 1'b1;
                end
            end
            S_WAIT: begin
                w_rom_addr = w_addr;
                if (cnt_q == '0) begin
                    shadow_d[idx_q] = rom.rom_data;
                    w_adv           = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Publishing on the edge into DONE makes blocked[] and done appear
        // together in the DONE cycle.
        if (w_adv) begin
            if (idx_q == C_LAST) begin
                state_d   = S_DONE;
                blocked_d = shadow_d;
                done_d    = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_ISSUE;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= '0;
            shadow_q  <= '0;
            blocked_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N_ACT; k++) begin
                x_q[k]   <= '0;
                y_q[k]   <= '0;
                dir_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            shadow_q  <= shadow_d;
            blocked_q <= blocked_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
        end
    end

    assign rom.rom_rd   = w_rom_rd;
    assign rom.rom_addr = w_rom_addr;
    assign blocked      = blocked_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire
